wear_level_allocator: RTL and testbench

//  Sequential, multi-mode successor to the combinational wear-level block selector.

---
 rtl/wear_level_allocator.sv | 97 +++++++++
 tb/tb_wear_level_allocator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wear_level_allocator.sv
// wear_level_allocator: multi-beat scan that returns the least-worn eligible block.
module wear_level_allocator #(
  parameter int BLOCKS = 64,
  parameter int ERASE_W = 16,
  parameter logic [ERASE_W-1:0] THRESHOLD = ERASE_W'(1000),
  parameter int LANES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BLOCKS*ERASE_W-1:0] erase_count_flat,
  input  logic [BLOCKS-1:0]         free_bitmap,
  input  logic                      req_valid,
  input  logic [1:0]                req_mode,
  output logic                      req_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_found,
  output logic [$clog2(BLOCKS)-1:0] resp_block,
  output logic [ERASE_W-1:0]        resp_erase,
  output logic                      busy
);
  localparam int NB = (BLOCKS + LANES - 1) / LANES;
  localparam int IW = $clog2(BLOCKS);
  localparam int BW = $clog2(NB) + 1;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t state, nxt;
  logic [1:0] mode;
  logic [BW-1:0] beat;
  logic [ERASE_W-1:0] min_c, b_c, c;
  logic [IW-1:0] min_i, b_i, bi;
  logic found, el, f;
  int idx;
  logic [ERASE_W-1:0] cnt [BLOCKS];
  for (genvar i = 0; i < BLOCKS; i++) begin : g_cnt
    assign cnt[i] = erase_count_flat[i*ERASE_W +: ERASE_W];
  end
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign busy       = state != IDLE;
  assign resp_found = found;
  assign resp_block = min_i;
  assign resp_erase = min_c;
  // Per-beat lane reduction; strict compare keeps the lowest lane on ties.
  always_comb begin
    b_c = '1;
    b_i = '0;
    idx = 0;
    bi = '0;
    c = '0;
    f = 1'b0;
    el = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(beat) * LANES + l;
      bi = idx < BLOCKS ? IW'(idx) : '0;
      c = cnt[bi];
      f = free_bitmap[bi];
      el = idx < BLOCKS && c != '1 &&
           (mode == 2'd0 ? f && c < THRESHOLD : mode == 2'd1 ? f : mode == 2'd2 ? !f : 1'b0);
      if (el && c < b_c) begin
        b_c = c;
        b_i = bi;
      end
    end
  end
  always_comb begin
    nxt = state == IDLE ? (req_valid ? SCAN : IDLE) :
          state == SCAN ? (beat == BW'(NB - 1) ? RESP : SCAN) :
          (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mode <= '0;
      beat <= '0;
      found <= 1'b0;
      min_c <= '1;
      min_i <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        mode <= req_mode;
        beat <= '0;
        found <= 1'b0;
        min_c <= '1;
        min_i <= '0;
      end
      if (state == SCAN) begin
        beat <= beat + 1'b1;
        if (b_c < min_c) begin
          found <= 1'b1;
          min_c <= b_c;
          min_i <= b_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_wear_level_allocator.sv
// tb_wear_level_allocator: scoreboard bench against a linear-scan reference model.
module tb_wear_level_allocator;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [15:0] cnt [64];
  logic [63:0] free;
  logic [64*16-1:0] flat0;
  logic [10*16-1:0] flat1;
  always_comb begin
    for (int i = 0; i < 64; i++) flat0[i*16 +: 16] = cnt[i];
    for (int i = 0; i < 10; i++) flat1[i*16 +: 16] = cnt[i];
  end
  logic rv_in [2], rr [2], rq_rdy [2], rs_v [2], fnd [2], bsy [2];
  logic [1:0] md [2];
  logic [15:0] er [2];
  logic [5:0] blk0;
  logic [3:0] blk1;

  wear_level_allocator dut0 (
    .clk(clk), .rst(rst), .erase_count_flat(flat0), .free_bitmap(free),
    .req_valid(rv_in[0]), .req_mode(md[0]), .req_ready(rq_rdy[0]),
    .resp_valid(rs_v[0]), .resp_ready(rr[0]), .resp_found(fnd[0]),
    .resp_block(blk0), .resp_erase(er[0]), .busy(bsy[0]));
  wear_level_allocator #(.BLOCKS(10), .LANES(4)) dut1 (
    .clk(clk), .rst(rst), .erase_count_flat(flat1), .free_bitmap(free[9:0]),
    .req_valid(rv_in[1]), .req_mode(md[1]), .req_ready(rq_rdy[1]),
    .resp_valid(rs_v[1]), .resp_ready(rr[1]), .resp_found(fnd[1]),
    .resp_block(blk1), .resp_erase(er[1]), .busy(bsy[1]));

  typedef struct {int d; int t; logic f; int b; logic [15:0] e;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Reference: lowest-index block holding the smallest eligible count.
  function automatic exp_t model(int d, logic [1:0] m);
    exp_t r;
    int n = d ? 10 : 64;
    r.d = d; r.t = 0; r.f = 1'b0; r.b = 0; r.e = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      logic el;
      el = cnt[i] != 16'hFFFF &&
           ((m == 0 && free[i] && cnt[i] < 16'd1000) || (m == 1 && free[i]) || (m == 2 && !free[i]));
      if (el && (!r.f || cnt[i] < r.e)) begin
        r.f = 1'b1; r.b = i; r.e = cnt[i];
      end
    end
    return r;
  endfunction

  logic seen = 1'b0;
  int seen_d = 0;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (rs_v[d] && !seen) begin
        if (q.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          chk("dut_sel", d, q[0].d);
          chk("latency", cyc - q[0].t, d ? 4 : 9);
          chk("found", fnd[d], q[0].f);
          chk("block", d ? blk1 : blk0, q[0].b);
          chk("erase", er[d], q[0].e);
        end
        seen = 1'b1;
        seen_d = d;
      end
    if (seen && !rs_v[seen_d]) begin
      seen = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
    end
  end

  task automatic issue(int d, logic [1:0] m);
    exp_t e;
    int k = 0;
    while (!rq_rdy[d] && k < 50) begin @(negedge clk); k++; end
    chk("req_ready_idle", rq_rdy[d], 1);
    e = model(d, m);
    e.t = cyc;
    q.push_back(e);
    md[d] = m;
    rv_in[d] = 1'b1;
    @(negedge clk);
    rv_in[d] = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (q.size() != 0 && k < 60) begin @(negedge clk); k++; end
    if (q.size() != 0) begin
      chk("resp_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic run(int d, logic [1:0] m);
    issue(d, m);
    wait_done();
    @(negedge clk);
  endtask

  task automatic fill_lin();
    for (int i = 0; i < 64; i++) cnt[i] = 16'(i * 10 + 5);
    free = '1;
  endtask

  task automatic fill_rand();
    int v = $urandom_range(0, 3);
    for (int i = 0; i < 64; i++)
      cnt[i] = v == 0 ? 16'($urandom_range(0, 2000)) : v == 1 ? 16'($urandom_range(0, 7)) :
               v == 2 ? 16'($urandom_range(990, 1010)) :
               ($urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom_range(0, 50)));
    free = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) free = free & {$urandom, $urandom} & {$urandom, $urandom};
  endtask

  initial begin
    logic fv;
    logic [5:0] bv;
    logic [15:0] ev;
    int k;
    for (int d = 0; d < 2; d++) begin rv_in[d] = 1'b0; rr[d] = 1'b1; md[d] = 2'd0; end
    fill_lin();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", rq_rdy[d], 1);
      chk("rst_resp_valid", rs_v[d], 0);
      chk("rst_found", fnd[d], 0);
      chk("rst_block", d ? blk1 : blk0, 0);
      chk("rst_erase", er[d], 16'hFFFF);
      chk("rst_busy", bsy[d], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    fill_lin(); cnt[37] = 16'd2;
    run(0, 2'd0);
    for (int i = 0; i < 64; i++) cnt[i] = 16'(1500 + i);
    cnt[5] = 16'd1000; cnt[9] = 16'd1200;
    run(0, 2'd0);
    run(0, 2'd1);
    for (int i = 0; i < 64; i++) cnt[i] = 16'd500;
    cnt[3] = 16'd7; cnt[20] = 16'd7; cnt[63] = 16'd7;
    run(0, 2'd0);
    free = 64'h8000_0000_0000_0000;
    run(0, 2'd0);
    fill_lin(); free[12] = 1'b0; free[50] = 1'b0; cnt[12] = 16'd40; cnt[50] = 16'd30;
    run(0, 2'd2);
    free = '1;
    run(0, 2'd2);
    free = 64'h1; cnt[0] = 16'hFFFF;
    run(0, 2'd1);
    fill_lin();
    run(0, 2'd3);
    fill_rand();
    rr[0] = 1'b0;
    issue(0, 2'd1);
    k = 0;
    while (!rs_v[0] && k < 30) begin @(negedge clk); k++; end
    chk("hold_resp_seen", rs_v[0], 1);
    fv = fnd[0]; bv = blk0; ev = er[0];
    rv_in[0] = 1'b1; md[0] = 2'd0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", rs_v[0], 1);
      chk("hold_found", fnd[0], fv);
      chk("hold_block", blk0, bv);
      chk("hold_erase", er[0], ev);
      chk("hold_req_ready", rq_rdy[0], 0);
    end
    rv_in[0] = 1'b0; rr[0] = 1'b1;
    wait_done();
    repeat (3) begin
      @(negedge clk);
      chk("no_queued_req", {rs_v[0], bsy[0]}, 0);
    end
    fill_lin(); cnt[37] = 16'd2;
    issue(0, 2'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("abort_valid", rs_v[0], 0);
    chk("abort_req_ready", rq_rdy[0], 1);
    chk("abort_busy", bsy[0], 0);
    chk("abort_erase", er[0], 16'hFFFF);
    repeat (12) @(negedge clk);
    chk("abort_no_resp", rs_v[0], 0);
    for (int i = 0; i < 64; i++) cnt[i] = 16'd0;
    free = '0; free[9] = 1'b1; free[10] = 1'b1; free[11] = 1'b1; cnt[9] = 16'd1;
    run(1, 2'd0);
    run(1, 2'd1);
    for (int it = 0; it < 48; it++) begin
      fill_rand();
      run(it % 4 == 3 ? 1 : 0, 2'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
